// File: rtl/uart_rx_frame_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_rx_frame_ctrl_if : CPU-side holding-register bus of the UART RX  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface uart_rx_frame_ctrl_if;
  logic       rdn;
  logic [7:0] d_out;
  logic       r_ready;
  logic       parity_error;
  logic       frame_error;
  logic       overrun_error;

  modport master (
    input  rdn,
    output d_out, r_ready, parity_error, frame_error, overrun_error
  );

  modport slave (
    output rdn,
    input  d_out, r_ready, parity_error, frame_error, overrun_error
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_rx_frame_ctrl : UART RX frame sequencer on clk16x with CPU        |
// | holding register. Option: UART_RX_MAJORITY_VOTE_EN (3-sample vote).    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module uart_rx_frame_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_TICK = 7
) (
  input  logic                        clk16x,
  input  logic                        clrn,
  input  logic                        rxd,
  input  logic [1:0]                  cfg_bits,
  input  logic                        cfg_par_en,
  input  logic                        cfg_par_odd,
  input  logic                        cfg_stop2,
  output logic                        busy,
  output logic                        bit_strobe,
  uart_rx_frame_ctrl_if.master        cpu
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] c_DEC_TICK = 4'(SAMPLE_TICK + 1);
`else
  localparam logic [3:0] c_DEC_TICK = 4'(SAMPLE_TICK);
`endif

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_rx;
  logic                   w_bit;
  logic                   w_dec;
  logic                   w_end;
  logic                   w_edge;
  logic                   w_commit;
  logic                   w_frm_fin;

  state_t                 r_state;
  logic [3:0]             r_tick;
  logic [2:0]             r_bit_idx;
  logic [2:0]             r_last_idx;
  logic                   r_par_en;
  logic                   r_par_odd;
  logic                   r_stop2;
  logic [7:0]             r_data;
  logic                   r_par_err;
  logic                   r_frm_err;

  logic [7:0]             r_dout;
  logic                   r_ready;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_oerr;
  logic                   r_busy;
  logic                   r_strobe;

  assign w_rx = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
      r_prev <= w_rx;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic r_vote0;
  logic r_vote1;

  // Two earlier samples are held; the third is the live synced value at decision time.
  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      r_vote0 <= 1'b1;
      r_vote1 <= 1'b1;
    end else begin
      if (r_tick == 4'(SAMPLE_TICK - 1)) r_vote0 <= w_rx;
      if (r_tick == 4'(SAMPLE_TICK))     r_vote1 <= w_rx;
    end
  end

  assign w_bit = (r_vote0 & r_vote1) | (r_vote0 & w_rx) | (r_vote1 & w_rx);
`else
  assign w_bit = w_rx;
`endif

  assign w_edge    = r_prev & ~w_rx;
  assign w_dec     = (r_state != S_IDLE) && (r_tick == c_DEC_TICK);
  assign w_end     = (r_tick == 4'hF);
  assign w_commit  = w_dec && (((r_state == S_STOP) && !r_stop2) || (r_state == S_STOP2));
  assign w_frm_fin = ~w_bit | ((r_state == S_STOP2) & r_frm_err);

  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      r_state    <= S_IDLE;
      r_tick     <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_last_idx <= 3'd0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_stop2    <= 1'b0;
      r_data     <= 8'd0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_dout     <= 8'd0;
      r_ready    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_oerr     <= 1'b0;
      r_busy     <= 1'b0;
      r_strobe   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (!cpu.rdn) begin
        r_ready <= 1'b0;
        r_perr  <= 1'b0;
        r_ferr  <= 1'b0;
        r_oerr  <= 1'b0;
      end
      if (r_state != S_IDLE) r_tick <= r_tick + 4'd1;

      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_state <= S_START;
            r_tick  <= 4'd0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_dec && w_bit) begin
            r_state <= S_IDLE;
            r_tick  <= 4'd0;
            r_busy  <= 1'b0;
          end else if (w_end) begin
            r_state    <= S_DATA;
            r_last_idx <= {1'b1, cfg_bits};
            r_par_en   <= cfg_par_en;
            r_par_odd  <= cfg_par_odd;
            r_stop2    <= cfg_stop2;
            r_data     <= 8'd0;
            r_bit_idx  <= 3'd0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_dec) begin
            r_data[r_bit_idx] <= w_bit;
            r_strobe          <= 1'b1;
          end
          if (w_end) begin
            if (r_bit_idx == r_last_idx) r_state <= r_par_en ? S_PARITY : S_STOP;
            else                         r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
        S_PARITY: begin
          if (w_dec) begin
            r_par_err <= ^r_data ^ w_bit ^ r_par_odd;
            r_strobe  <= 1'b1;
          end
          if (w_end) r_state <= S_STOP;
        end
        S_STOP: begin
          if (w_dec) begin
            r_strobe  <= 1'b1;
            r_frm_err <= ~w_bit;
          end
          if (w_end) r_state <= S_STOP2;
        end
        S_STOP2: begin
          if (w_dec) r_strobe <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase

      // The last stop decision returns to IDLE at once so a following start edge is not missed.
      if (w_commit) begin
        r_state <= S_IDLE;
        r_tick  <= 4'd0;
        r_busy  <= 1'b0;
        if (!r_ready || !cpu.rdn) begin
          r_dout  <= r_data;
          r_perr  <= r_par_err;
          r_ferr  <= w_frm_fin;
          r_ready <= 1'b1;
        end else begin
          r_oerr  <= 1'b1;
        end
      end
    end
  end

  assign cpu.d_out         = r_dout;
  assign cpu.r_ready       = r_ready;
  assign cpu.parity_error  = r_perr;
  assign cpu.frame_error   = r_ferr;
  assign cpu.overrun_error = r_oerr;
  assign busy              = r_busy;
  assign bit_strobe        = r_strobe;

endmodule
`default_nettype wire
